// File: rtl/param_control_pkg.sv
// Shared encodings, limits and parameter-set layout for the front-panel controller.
package param_control_pkg;

  localparam logic [2:0] MODE_AMP    = 3'b000;
  localparam logic [2:0] MODE_MIN    = 3'b001;
  localparam logic [2:0] MODE_MAX    = 3'b010;
  localparam logic [2:0] MODE_FREQ   = 3'b011;
  localparam logic [2:0] MODE_DUTY   = 3'b110;
  localparam logic [2:0] MODE_OFFSET = 3'b111;

  localparam logic [11:0] VMAX   = 12'd4092;
  localparam logic [11:0] STEP_V = 12'd124;

  localparam logic [16:0] FREQ_MIN   = 17'd1;
  localparam logic [16:0] FREQ_MAX   = 17'd8999;
  localparam logic [16:0] FREQ_STEP  = 17'd10;
  localparam logic [16:0] FREQ_RESET = 17'd1000;

  localparam logic [6:0] DUTY_MIN   = 7'd1;
  localparam logic [6:0] DUTY_MAX   = 7'd99;
  localparam logic [6:0] DUTY_RESET = 7'd50;

  typedef struct packed {
    logic [11:0] lo;
    logic [11:0] hi;
    logic [6:0]  duty;
    logic [16:0] freq;
  } params_t;

  localparam params_t PAR_RESET = '{lo: 12'd0, hi: VMAX, duty: DUTY_RESET, freq: FREQ_RESET};

endpackage

// File: rtl/param_control_if.sv
// Front-panel bundle: raw buttons/switches in, registered display-stage outputs back.
interface param_control_if;
  logic        btnUp;
  logic        btnDown;
  logic [2:0]  modeSw;
  logic [1:0]  waveSw;
  logic [2:0]  mode;
  logic [1:0]  waveform;
  logic [11:0] minimum;
  logic [11:0] maximum;
  logic [6:0]  duty;
  logic [16:0] frequency;
  logic        paramChanged;

  modport master (
    output btnUp, btnDown, modeSw, waveSw,
    input  mode, waveform, minimum, maximum, duty, frequency, paramChanged
  );

  modport slave (
    input  btnUp, btnDown, modeSw, waveSw,
    output mode, waveform, minimum, maximum, duty, frequency, paramChanged
  );
endinterface

// File: rtl/param_control_button_conditioner.sv
// One push-button: 2-FF sync, debounce, and IDLE/HOLD/REPEAT auto-repeat producing a one-clock step.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_restart,
  output logic o_step
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic          r_s1, r_s2, r_db;
  logic [DW-1:0] r_db_cnt;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic [1:0]    r_state, w_state_nxt;
  logic [RW-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic          w_step;

  // r_armed blocks a press held through reset: the button must first be seen released
  // once the synchroniser output is meaningful (r_vld[1]).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_vld    <= '0;
      r_armed  <= 1'b0;
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_s2 & ~r_db);
      if (r_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db     <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_step        = 1'b0;
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt + 1'b1;
    if (!r_db) begin
      w_state_nxt   = ST_IDLE;
      w_rep_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_rep_cnt_nxt = '0;
          if (r_armed) begin
            w_step      = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_restart) begin
            w_rep_cnt_nxt = '0;
          end else if (r_rep_cnt == DLY_LAST) begin
            w_step        = 1'b1;
            w_state_nxt   = ST_REPEAT;
            w_rep_cnt_nxt = '0;
          end
        end
        ST_REPEAT: begin
          if (i_restart) begin
            w_state_nxt   = ST_HOLD;
            w_rep_cnt_nxt = '0;
          end else if (r_rep_cnt == RPT_LAST) begin
            w_step        = 1'b1;
            w_rep_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_rep_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
    end
  end

  assign o_step = w_step;

endmodule

// File: rtl/param_control.sv
// Front-panel controller: switch synchronisers, two button conditioners and clamped parameter registers.
module param_control
  import param_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  param_control_if.slave  bus
);

  localparam logic [12:0] S13  = 13'(STEP_V);
  localparam logic [12:0] S2_13 = 13'(2 * STEP_V);
  localparam logic [12:0] V13  = 13'(VMAX);

  logic [2:0]  r_mode_s1, r_mode;
  logic [1:0]  r_wave_s1, r_wave;
  logic        w_up_step, w_dn_step, w_up, w_dn, w_restart;
  params_t     r_par, w_nxt;
  logic        r_pc;
  logic [12:0] w_lo13, w_hi13;
  logic [16:0] w_fup;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_s1 <= '0;
      r_mode    <= '0;
      r_wave_s1 <= '0;
      r_wave    <= '0;
    end else begin
      r_mode_s1 <= bus.modeSw;
      r_mode    <= r_mode_s1;
      r_wave_s1 <= bus.waveSw;
      r_wave    <= r_wave_s1;
    end
  end

  // Restart the repeat timing in the same cycle the new mode becomes visible.
  assign w_restart = (r_mode_s1 != r_mode);

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE))
    u_btn_up (.clk(clk), .rst(reset), .i_btn(bus.btnUp), .i_restart(w_restart), .o_step(w_up_step));

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE))
    u_btn_dn (.clk(clk), .rst(reset), .i_btn(bus.btnDown), .i_restart(w_restart), .o_step(w_dn_step));

  assign w_up   = w_up_step & ~w_dn_step;
  assign w_dn   = w_dn_step & ~w_up_step;
  assign w_lo13 = {1'b0, r_par.lo};
  assign w_hi13 = {1'b0, r_par.hi};
  assign w_fup  = r_par.freq + FREQ_STEP;

  always_comb begin
    w_nxt = r_par;
    case (r_mode)
      MODE_AMP: begin
        if (w_up) begin
          if (w_hi13 + S13 <= V13)  w_nxt.hi = r_par.hi + STEP_V;
          else if (w_lo13 >= S13)   w_nxt.lo = r_par.lo - STEP_V;
        end else if (w_dn && (w_hi13 - w_lo13 >= S2_13)) begin
          w_nxt.hi = r_par.hi - STEP_V;
        end
      end
      MODE_MIN: begin
        if (w_up && (w_lo13 + S2_13 <= w_hi13)) w_nxt.lo = r_par.lo + STEP_V;
        else if (w_dn && (w_lo13 >= S13))       w_nxt.lo = r_par.lo - STEP_V;
      end
      MODE_MAX: begin
        if (w_up && (w_hi13 + S13 <= V13))          w_nxt.hi = r_par.hi + STEP_V;
        else if (w_dn && (w_hi13 >= w_lo13 + S2_13)) w_nxt.hi = r_par.hi - STEP_V;
      end
      MODE_FREQ: begin
        if (w_up)      w_nxt.freq = (w_fup > FREQ_MAX) ? FREQ_MAX : w_fup;
        else if (w_dn) w_nxt.freq = (r_par.freq < FREQ_MIN + FREQ_STEP) ? FREQ_MIN
                                                                         : r_par.freq - FREQ_STEP;
      end
      MODE_DUTY: begin
        if (r_wave == 2'd1) begin
          if (w_up && (r_par.duty < DUTY_MAX))      w_nxt.duty = r_par.duty + 7'd1;
          else if (w_dn && (r_par.duty > DUTY_MIN)) w_nxt.duty = r_par.duty - 7'd1;
        end
      end
      MODE_OFFSET: begin
        if (w_up && (w_hi13 + S13 <= V13)) begin
          w_nxt.lo = r_par.lo + STEP_V;
          w_nxt.hi = r_par.hi + STEP_V;
        end else if (w_dn && (w_lo13 >= S13)) begin
          w_nxt.lo = r_par.lo - STEP_V;
          w_nxt.hi = r_par.hi - STEP_V;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= PAR_RESET;
      r_pc  <= 1'b0;
    end else begin
      r_par <= w_nxt;
      r_pc  <= (w_nxt != r_par);
    end
  end

  assign bus.mode         = r_mode;
  assign bus.waveform     = r_wave;
  assign bus.minimum      = r_par.lo;
  assign bus.maximum      = r_par.hi;
  assign bus.duty         = r_par.duty;
  assign bus.frequency    = r_par.freq;
  assign bus.paramChanged = r_pc;

endmodule

// File: tb/tb_param_control.sv
// Directed bench for param_control with short debounce/repeat timing.
module tb_param_control;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pulse = 0;
  int   p0;

  param_control_if bus ();

  param_control #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.paramChanged === 1'b1) n_pulse++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [2:0] m, input logic [1:0] w);
    bus.modeSw = m;
    bus.waveSw = w;
    tick(3);
  endtask

  // Debounced level stays high for 10 cycles: one step, no auto-repeat.
  task automatic press(input logic up, input logic dn);
    bus.btnUp   = up;
    bus.btnDown = dn;
    tick(10);
    bus.btnUp   = 1'b0;
    bus.btnDown = 1'b0;
    tick(12);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    n_cmp++; if (bus.mode !== 3'd0) begin n_err++; $display("FAIL rst_mode: got %0d expected 0", bus.mode); end
    n_cmp++; if (bus.waveform !== 2'd0) begin n_err++; $display("FAIL rst_wave: got %0d expected 0", bus.waveform); end
    n_cmp++; if (bus.minimum !== 12'd0) begin n_err++; $display("FAIL rst_min: got %0d expected 0", bus.minimum); end
    n_cmp++; if (bus.maximum !== 12'd4092) begin n_err++; $display("FAIL rst_max: got %0d expected 4092", bus.maximum); end
    n_cmp++; if (bus.duty !== 7'd50) begin n_err++; $display("FAIL rst_duty: got %0d expected 50", bus.duty); end
    n_cmp++; if (bus.frequency !== 17'd1000) begin n_err++; $display("FAIL rst_freq: got %0d expected 1000", bus.frequency); end
    n_cmp++; if (bus.paramChanged !== 1'b0) begin n_err++; $display("FAIL rst_pc: got %0b expected 0", bus.paramChanged); end
    tick(2);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_max_clamp;
    set_mode(3'b010, 2'd0);
    n_cmp++; if (bus.mode !== 3'b010) begin n_err++; $display("FAIL sync_mode: got %0d expected 2", bus.mode); end
    p0 = n_pulse;
    press(1'b1, 1'b0);
    n_cmp++; if (bus.maximum !== 12'd4092) begin n_err++; $display("FAIL max_clamp: got %0d expected 4092", bus.maximum); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL max_clamp_pc: got %0d pulses expected 0", n_pulse - p0); end
    bus.btnDown = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        n_cmp++; if (bus.maximum !== 12'd4092) begin n_err++; $display("FAIL lat_early_max: got %0d expected 4092", bus.maximum); end
        n_cmp++; if (bus.paramChanged !== 1'b0) begin n_err++; $display("FAIL lat_early_pc: got %0b expected 0", bus.paramChanged); end
      end
      if (k == 7) begin
        n_cmp++; if (bus.maximum !== 12'd3968) begin n_err++; $display("FAIL lat_max: got %0d expected 3968", bus.maximum); end
        n_cmp++; if (bus.paramChanged !== 1'b1) begin n_err++; $display("FAIL lat_pc: got %0b expected 1", bus.paramChanged); end
      end
      if (k == 8) begin
        n_cmp++; if (bus.paramChanged !== 1'b0) begin n_err++; $display("FAIL pc_width: got %0b expected 0", bus.paramChanged); end
      end
    end
    tick(4);
    bus.btnDown = 1'b0;
    tick(12);
    n_cmp++; if (bus.maximum !== 12'd3968) begin n_err++; $display("FAIL max_single: got %0d expected 3968", bus.maximum); end
  endtask

  task automatic test_bounce;
    set_mode(3'b001, 2'd0);
    p0 = n_pulse;
    bus.btnUp = 1'b1; tick(2);
    bus.btnUp = 1'b0; tick(2);
    bus.btnUp = 1'b1; tick(2);
    bus.btnUp = 1'b0; tick(2);
    bus.btnUp = 1'b1; tick(10);
    bus.btnUp = 1'b0; tick(12);
    n_cmp++; if (bus.minimum !== 12'd124) begin n_err++; $display("FAIL bounce_min: got %0d expected 124", bus.minimum); end
    n_cmp++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL bounce_pc: got %0d pulses expected 1", n_pulse - p0); end
  endtask

  task automatic test_freq_repeat;
    set_mode(3'b011, 2'd0);
    p0 = n_pulse;
    bus.btnUp = 1'b1;
    tick(44);
    bus.btnUp = 1'b0;
    tick(14);
    n_cmp++; if (bus.frequency !== 17'd1060) begin n_err++; $display("FAIL repeat_freq: got %0d expected 1060", bus.frequency); end
    n_cmp++; if (n_pulse - p0 !== 6) begin n_err++; $display("FAIL repeat_pc: got %0d pulses expected 6", n_pulse - p0); end
    tick(20);
    n_cmp++; if (bus.frequency !== 17'd1060) begin n_err++; $display("FAIL release_freq: got %0d expected 1060", bus.frequency); end
  endtask

  task automatic test_offset;
    set_mode(3'b001, 2'd0);
    repeat (30) press(1'b1, 1'b0);
    n_cmp++; if (bus.minimum !== 12'd3844) begin n_err++; $display("FAIL min_walk: got %0d expected 3844", bus.minimum); end
    set_mode(3'b111, 2'd0);
    press(1'b1, 1'b0);
    n_cmp++; if (bus.minimum !== 12'd3968) begin n_err++; $display("FAIL ofs_up_min: got %0d expected 3968", bus.minimum); end
    n_cmp++; if (bus.maximum !== 12'd4092) begin n_err++; $display("FAIL ofs_up_max: got %0d expected 4092", bus.maximum); end
    p0 = n_pulse;
    press(1'b1, 1'b0);
    n_cmp++; if (bus.maximum !== 12'd4092) begin n_err++; $display("FAIL ofs_clamp_max: got %0d expected 4092", bus.maximum); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL ofs_clamp_pc: got %0d pulses expected 0", n_pulse - p0); end
    repeat (32) press(1'b0, 1'b1);
    n_cmp++; if (bus.minimum !== 12'd0) begin n_err++; $display("FAIL ofs_dn_min: got %0d expected 0", bus.minimum); end
    n_cmp++; if (bus.maximum !== 12'd124) begin n_err++; $display("FAIL ofs_dn_max: got %0d expected 124", bus.maximum); end
    p0 = n_pulse;
    press(1'b0, 1'b1);
    n_cmp++; if (bus.maximum !== 12'd124) begin n_err++; $display("FAIL ofs_floor_max: got %0d expected 124", bus.maximum); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL ofs_floor_pc: got %0d pulses expected 0", n_pulse - p0); end
  endtask

  task automatic test_duty;
    set_mode(3'b110, 2'd0);
    p0 = n_pulse;
    press(1'b1, 1'b0);
    n_cmp++; if (bus.duty !== 7'd50) begin n_err++; $display("FAIL duty_gated: got %0d expected 50", bus.duty); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL duty_gated_pc: got %0d pulses expected 0", n_pulse - p0); end
    set_mode(3'b110, 2'd1);
    n_cmp++; if (bus.waveform !== 2'd1) begin n_err++; $display("FAIL sync_wave: got %0d expected 1", bus.waveform); end
    repeat (49) press(1'b1, 1'b0);
    n_cmp++; if (bus.duty !== 7'd99) begin n_err++; $display("FAIL duty_walk: got %0d expected 99", bus.duty); end
    p0 = n_pulse;
    press(1'b1, 1'b0);
    n_cmp++; if (bus.duty !== 7'd99) begin n_err++; $display("FAIL duty_clamp: got %0d expected 99", bus.duty); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL duty_clamp_pc: got %0d pulses expected 0", n_pulse - p0); end
    press(1'b0, 1'b1);
    n_cmp++; if (bus.duty !== 7'd98) begin n_err++; $display("FAIL duty_down: got %0d expected 98", bus.duty); end
  endtask

  task automatic test_simultaneous;
    set_mode(3'b011, 2'd1);
    p0 = n_pulse;
    press(1'b1, 1'b1);
    n_cmp++; if (bus.frequency !== 17'd1060) begin n_err++; $display("FAIL both_freq: got %0d expected 1060", bus.frequency); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL both_pc: got %0d pulses expected 0", n_pulse - p0); end
  endtask

  task automatic test_reset_mid_repeat;
    bus.btnUp = 1'b1;
    tick(35);
    n_cmp++; if (bus.frequency !== 17'd1090) begin n_err++; $display("FAIL pre_rst_freq: got %0d expected 1090", bus.frequency); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.mode !== 3'd0) begin n_err++; $display("FAIL arst_mode: got %0d expected 0", bus.mode); end
    n_cmp++; if (bus.waveform !== 2'd0) begin n_err++; $display("FAIL arst_wave: got %0d expected 0", bus.waveform); end
    n_cmp++; if (bus.minimum !== 12'd0) begin n_err++; $display("FAIL arst_min: got %0d expected 0", bus.minimum); end
    n_cmp++; if (bus.maximum !== 12'd4092) begin n_err++; $display("FAIL arst_max: got %0d expected 4092", bus.maximum); end
    n_cmp++; if (bus.duty !== 7'd50) begin n_err++; $display("FAIL arst_duty: got %0d expected 50", bus.duty); end
    n_cmp++; if (bus.frequency !== 17'd1000) begin n_err++; $display("FAIL arst_freq: got %0d expected 1000", bus.frequency); end
    n_cmp++; if (bus.paramChanged !== 1'b0) begin n_err++; $display("FAIL arst_pc: got %0b expected 0", bus.paramChanged); end
    #2;
    reset = 1'b0;
    p0 = n_pulse;
    tick(40);
    n_cmp++; if (bus.frequency !== 17'd1000) begin n_err++; $display("FAIL held_freq: got %0d expected 1000", bus.frequency); end
    n_cmp++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL held_pc: got %0d pulses expected 0", n_pulse - p0); end
    bus.btnUp = 1'b0;
    tick(12);
    press(1'b1, 1'b0);
    n_cmp++; if (bus.frequency !== 17'd1010) begin n_err++; $display("FAIL repress_freq: got %0d expected 1010", bus.frequency); end
  endtask

  initial begin
    reset       = 1'b1;
    bus.btnUp   = 1'b0;
    bus.btnDown = 1'b0;
    bus.modeSw  = 3'd0;
    bus.waveSw  = 2'd0;
    test_reset;
    test_max_clamp;
    test_bounce;
    test_freq_repeat;
    test_offset;
    test_duty;
    test_simultaneous;
    test_reset_mid_repeat;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_control.md
Name: param_control

Overview:
- Front-panel controller that produces the mode, waveform and parameter set consumed by the 7-segment display stage and the waveform generator.
- Conditions two push-buttons (up/down) with sync, debounce and auto-repeat.
- Steps the parameter selected by the mode switches, with range and ordering clamps.
- All outputs are registered and drive the display stage directly.

Parameters:
DEBOUNCE_CYCLES, 1000000, clocks a synchronised button must be stable before it is accepted
REPEAT_DELAY, 50000000, clocks a held button waits before the first auto-repeat step
REPEAT_RATE, 10000000, clocks between auto-repeat steps after the first
STEP_V, 124, code step for voltage parameters (0.1 V per step)
VMAX, 4092, maximum voltage code (3.3 V)
FREQ_MIN, 1, lowest frequency
FREQ_MAX, 8999, highest frequency (display limit)
FREQ_STEP, 10, frequency increment per step
DUTY_RESET, 50, duty value after reset
FREQ_RESET, 1000, frequency value after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btnUp  in  1  raw up button, asynchronous to clk
btnDown  in  1  raw down button, asynchronous to clk
modeSw  in  3  raw mode switches
waveSw  in  2  raw waveform switches
mode  out  3  synchronised mode: 000 amplitude, 001 min, 010 max, 011 freq, 110 duty, 111 offset, 100/101 unused
waveform  out  2  synchronised waveform select
minimum  out  12  minimum voltage code
maximum  out  12  maximum voltage code
duty  out  7  duty cycle in percent
frequency  out  17  frequency
paramChanged  out  1  one-clock pulse on the cycle a parameter register changes

Behaviour:
- Reset: async, active-high. Values: mode=0, waveform=0, minimum=0, maximum=VMAX, duty=DUTY_RESET, frequency=FREQ_RESET, paramChanged=0; all counters and synchroniser flops cleared.
- Switch path: modeSw/waveSw pass through a 2-FF synchroniser. mode/waveform equal modeSw/waveSw delayed 2 clocks. No debounce on switches.
- Button path, per button: 2-FF sync, then debounce counter. The debounced level changes only after the sync output has differed from it for DEBOUNCE_CYCLES consecutive clocks; any bounce restarts the count.
- Step pulse: one clock wide, on the debounced 0->1 edge. Auto-repeat while the debounced level stays 1:
  - IDLE -> (debounced rise, emit step) -> HOLD.
  - HOLD -> (REPEAT_DELAY clocks, emit step) -> REPEAT.
  - REPEAT -> (every REPEAT_RATE clocks, emit step) -> REPEAT.
  - Any state -> (debounced 0) -> IDLE.
- Mode change while a button is held: the repeat FSM returns to HOLD and restarts its counter.
- Latency: a clean raw button rise updates the parameter register DEBOUNCE_CYCLES+3 clocks later. paramChanged asserts in that same cycle.
- Simultaneous up and down step pulses in one clock: both ignored, no change, no paramChanged.
- Step rules: compare in 13-bit to avoid overflow. A step that would violate a clamp leaves all values unchanged and gives no paramChanged.
  - 000 amplitude, up: if max+STEP_V<=VMAX then max+=STEP_V; else if min>=STEP_V then min-=STEP_V.
  - 000 amplitude, down: if max-min>=2*STEP_V then max-=STEP_V.
  - 001 minimum, up: if min+2*STEP_V<=max then min+=STEP_V.
  - 001 minimum, down: if min>=STEP_V then min-=STEP_V.
  - 010 maximum, up: if max+STEP_V<=VMAX then max+=STEP_V.
  - 010 maximum, down: if max>=min+2*STEP_V then max-=STEP_V.
  - 011 frequency, up: frequency = min(frequency+FREQ_STEP, FREQ_MAX).
  - 011 frequency, down: frequency = max(frequency-FREQ_STEP, FREQ_MIN). A saturated value counts as unchanged if equal to the old value.
  - 110 duty: active only when waveform==1. up: +1 to 99 max; down: -1 to 1 min.
  - 111 offset, up: if max+STEP_V<=VMAX then min and max both +=STEP_V.
  - 111 offset, down: if min>=STEP_V then both -=STEP_V.
  - 100/101: steps ignored.
- Invariants, holding at all times: min+STEP_V<=max; max<=VMAX; 1<=duty<=99; FREQ_MIN<=frequency<=FREQ_MAX.
- Reset mid-hold: FSM returns to IDLE. No step is issued until the button is released and pressed again.

Decomposition:
- Shared package: mode encodings (MODE_AMP, MODE_MIN, MODE_MAX, MODE_FREQ, MODE_DUTY, MODE_OFFSET), VMAX, STEP_V, frequency and duty limits.
- Sub-module button_conditioner: sync, debounce, edge detect and repeat FSM, producing the step pulse. Instantiated twice.
- param_control holds the switch synchronisers, the parameter registers and the clamp logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset then mode=010, one clean btnUp press -> maximum stays 4092 (clamped), no paramChanged. Then btnDown -> maximum=3968 at press+7 clocks, paramChanged high exactly 1 clock.
- btnUp bouncing 1,0,1,0 at 2-clock intervals, then stable -> exactly one step. In mode 001 with min=0: min=124.
- Mode 011, freq=1000, hold btnUp 41 clocks past debounce -> steps at 0, 20, 25, 30, 35, 40 -> frequency=1060. Release -> no further change.
- Mode 111, min=3844, max=3968: up -> min=3968, max=4092. Second up -> unchanged. down x32 -> min=0, max=124 and stays there.
- Mode 110, waveform=0: up -> duty stays 50. waveform=1, duty=99: up -> 99; down -> 98.
- btnUp and btnDown step on the same clock -> no change, no paramChanged. Reset asserted mid-repeat -> all outputs at reset values immediately (async).
